// File: rtl/inst_fetch_if_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// inst_fetch_if_pkg : shared types and encodings for the instruction fetch path
// Rev 1.0
// -----------------------------------------------------------------------------
package inst_fetch_if_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam logic [0:0] c_FETCH_IDLE = 1'b0;
  localparam logic [0:0] c_FETCH_BUSY = 1'b1;

  localparam inst_t c_NOP_INST    = 32'h0000_0000;
  localparam logic  c_RST_ENABLE  = 1'b1;
  localparam logic  c_CHIP_ENABLE = 1'b1;
  localparam logic  c_STOP        = 1'b1;
  localparam logic  c_NO_STOP     = 1'b0;

  function automatic logic is_word_aligned(input inst_addr_t addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if_tcnt.sv
`default_nettype none
// -----------------------------------------------------------------------------
// inst_fetch_if_tcnt : 8-bit bus wait counter with clear, enable and expiry flag
// Rev 1.0
// -----------------------------------------------------------------------------
module inst_fetch_if_tcnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] c_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry only means something while a request is outstanding.
  assign expired_o = en_i & (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// inst_fetch_if : fetch responder with one-entry tagged buffer and req/ack bus
// Rev 1.0
// -----------------------------------------------------------------------------
module inst_fetch_if
  import inst_fetch_if_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] RESET_INST  = c_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stallreq,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  logic [0:0] state_q,     state_d;
  logic       bus_req_q,   bus_req_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic       buf_valid_q, buf_valid_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic       drop_q,      drop_d;
  logic       bus_err_q,   bus_err_d;

  logic w_hit;
  logic w_mis;
  logic w_miss;
  logic w_issue;
  logic w_busy;
  logic w_expired;

  assign w_hit   = (ce == c_CHIP_ENABLE) & buf_valid_q & (buf_addr_q == pc) & ~drop_q;
  assign w_mis   = (ce == c_CHIP_ENABLE) & ~is_word_aligned(pc);
  assign w_miss  = (ce == c_CHIP_ENABLE) & ~w_hit & ~w_mis & ~flush;
  assign w_busy  = (state_q == c_FETCH_BUSY);
  assign w_issue = ~w_busy & w_miss;

  inst_fetch_if_tcnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tcnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (w_issue),
    .en_i      (w_busy),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst == c_RST_ENABLE) begin
      state_q     <= c_FETCH_IDLE;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      drop_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      drop_q      <= drop_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_FETCH_IDLE: if (w_miss) state_d = c_FETCH_BUSY;
      c_FETCH_BUSY: if (bus_ack || w_expired) state_d = c_FETCH_IDLE;
      default:      state_d = c_FETCH_IDLE;
    endcase
  end

  always_comb begin
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    drop_d      = drop_q;
    bus_err_d   = 1'b0;
    case (state_q)
      c_FETCH_IDLE: begin
        if (w_miss) begin
          bus_req_d  = 1'b1;
          bus_addr_d = pc;
        end
      end
      c_FETCH_BUSY: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          // A flush in the ack cycle discards the word just like an earlier one.
          if (drop_q || flush) begin
            buf_valid_d = 1'b0;
            drop_d      = 1'b0;
          end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = bus_addr_q;
            buf_data_d  = bus_rdata;
          end
        end else if (w_expired) begin
          bus_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          buf_valid_d = 1'b0;
          drop_d      = 1'b0;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        bus_req_d = 1'b0;
      end
    endcase
    if (flush) begin
      buf_valid_d = 1'b0;
    end
  end

  always_comb begin
    inst       = RESET_INST;
    inst_valid = 1'b0;
    stallreq   = c_NO_STOP;
    if (rst != c_RST_ENABLE) begin
      inst       = w_hit ? buf_data_q : RESET_INST;
      inst_valid = w_hit;
      stallreq   = w_miss ? c_STOP : c_NO_STOP;
    end
  end

  assign misalign = w_mis;
  assign bus_err  = bus_err_q;
  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;

endmodule
`default_nettype wire

// File: doc/inst_fetch_if.md
Name: inst_fetch_if

Overview:
Responder for the PC stage's fetch request.
- Accepts the fetch address `pc` and its enable `ce`.
- Fetches the 32-bit instruction over a simple req/ack memory bus.
- Presents the instruction to the IF/ID register and requests a pipeline stall from ctrl until the word is available.
- Holds a one-entry address-tagged fetch buffer.
- Handles flush, misaligned addresses and bus timeout.

Parameters:
TIMEOUT_CYC, 16, max cycles waiting for bus_ack before declaring bus_err (range 2..255)
RESET_INST, 32'h00000000, value driven on inst when no valid instruction (MIPS nop)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset; synchronous, active-high (`RstEnable` = 1'b1)
pc  input  32  fetch address from PC stage
ce  input  1  fetch enable from PC stage (`ChipEnable` = 1)
flush  input  1  pipeline flush from ctrl
inst  output  32  fetched instruction to IF/ID
inst_valid  output  1  inst corresponds to current pc
stallreq  output  1  stall request to ctrl (ctrl freezes stall[0])
misalign  output  1  pc[1:0] != 0 while ce=1
bus_err  output  1  one-cycle pulse on bus timeout
bus_req  output  1  memory read request, held until ack
bus_addr  output  32  word address of request (registered)
bus_ack  input  1  memory returns data this cycle
bus_rdata  input  32  read data, valid with bus_ack

Behaviour:
Reset (rst=1 at clk edge):
- state=IDLE; bus_req=0; bus_addr=0; buf_valid=0; buf_addr=0; buf_data=0; drop=0; tcnt=0; bus_err=0.
- Combinational outputs are forced while rst=1: stallreq=0, inst=RESET_INST, inst_valid=0.
- rst mid-transaction abandons it. A late bus_ack after reset is ignored (IDLE ignores ack).

Combinational terms:
- hit = ce & buf_valid & (buf_addr == pc) & ~drop
- mis = ce & (pc[1:0] != 2'b00)
- inst = hit ? buf_data : RESET_INST
- inst_valid = hit
- misalign = mis
- stallreq = ce & ~hit & ~mis & ~flush

FSM states: IDLE, BUSY.
- IDLE:
  - If ce & ~hit & ~mis & ~flush: bus_req<=1, bus_addr<=pc, tcnt<=0, state<=BUSY.
  - Else remain.
- BUSY:
  - bus_req stays 1 and tcnt increments each cycle.
  - On bus_ack: bus_req<=0; state<=IDLE.
    - If drop=0: buf_data<=bus_rdata, buf_addr<=bus_addr, buf_valid<=1.
    - If drop=1: buf_valid<=0, drop<=0.
  - On tcnt==TIMEOUT_CYC-1 without ack: bus_req<=0, bus_err<=1 for one cycle, buf_valid<=0, drop<=0, state<=IDLE. The request re-issues on the next IDLE cycle if still missing.

Flush:
- Any cycle with flush=1 sets buf_valid<=0.
- In BUSY, flush also sets drop<=1. The outstanding bus transaction cannot be aborted; its data is discarded.
- flush and ack in the same cycle: data discarded.

Latency:
- Miss with ack one cycle after req gives 3 cycles of stallreq: issue cycle, ack cycle, buffer-update edge. inst_valid rises the cycle after ack.
- Hit gives 0 added latency.

Other boundary conditions:
- ce=0 while BUSY: transaction completes and fills the buffer normally.
- Misaligned pc: no bus access, inst=nop, inst_valid=0, no stall.
- pc == buf_addr after wrap 32'hFFFFFFFC -> 0: plain compare, no special case.
- bus_ack while IDLE is ignored.
- At most one outstanding request.

Decomposition:
- Shared defines header additions:
  - `InstAddrBus`, `InstBus` (31:0)
  - `FetchIdle`/`FetchBusy` state encodings (1 bit)
  - `NopInst` 32'h0
- Reuse existing `RstEnable`, `ChipEnable`, `Stop`/`NoStop`.
- Optional sub-module fetch_timeout_cnt: 8-bit counter with clear, enable, expiry flag. The remainder stays flat.

Test Plan:
1. Reset held 3 cycles with bus_ack toggling -> bus_req=0, stallreq=0, inst=0, inst_valid=0 throughout.
2. ce=1, pc=0x00000000, memory acks 1 cycle after req with 0x24010005 -> bus_addr=0x0, stallreq high 3 cycles, then inst=0x24010005, inst_valid=1, stallreq=0.
3. pc advances 0x0 -> 0x4, ack delay 4 cycles, rdata 0x8C220000 -> stallreq high 6 cycles, single bus_req pulse train, inst updates once.
4. Flush asserted in 2nd BUSY cycle, pc changed to 0x80 -> first ack data discarded (inst_valid stays 0), new request issued with bus_addr=0x80, then its data is delivered.
5. pc=0x00000006, ce=1 -> misalign=1, stallreq=0, bus_req never asserts, inst=0.
6. TIMEOUT_CYC=4, bus_ack never -> bus_err pulses once 4 cycles after req; bus_req drops for one cycle, then re-asserts; stallreq remains 1.
